// File: rtl/camera_config_seq.sv
// rtl/camera_config_seq.sv - ROM-driven SCCB register configuration sequencer
//
// Walks a configuration ROM of {regAddr, regData} words and issues one SCCB
// write per entry. 16'hFFFF ends the sequence; 16'hFFF0 inserts a wait of
// DELAY_CYCLES clocks. A NACKed write is retried up to MAX_RETRY times
// before the sequence aborts.
//
// Ports:
//   i_clk, i_reset (async, active-low)  clock and reset
//   i_startConf                         active-low start; falling edge starts
//   o_romAddr / i_romData               ROM address out, word back next cycle
//   o_sccbReq / i_sccbReady             write request / accept handshake
//   o_sccbDevAddr, o_sccbRegAddr,
//   o_sccbData                          write target and payload
//   i_sccbDone / i_sccbNack             completion pulse and its NACK flag
//   o_configBusy, o_configDone,
//   o_configErr                         sequence status levels
module camera_config_seq #(
    parameter int         ROM_DEPTH    = 256,
    parameter logic [7:0] DEV_ADDR     = 8'h42,
    parameter int         DELAY_CYCLES = 500000,
    parameter int         MAX_RETRY    = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_startConf,
    output logic [7:0]  o_romAddr,
    input  logic [15:0] i_romData,
    output logic        o_sccbReq,
    output logic [7:0]  o_sccbDevAddr,
    output logic [7:0]  o_sccbRegAddr,
    output logic [7:0]  o_sccbData,
    input  logic        i_sccbReady,
    input  logic        i_sccbDone,
    input  logic        i_sccbNack,
    output logic        o_configBusy,
    output logic        o_configDone,
    output logic        o_configErr
);

    localparam int              DW        = $clog2(DELAY_CYCLES + 1);
    localparam int              RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [7:0]      LAST_ADDR = 8'(ROM_DEPTH - 1);
    localparam logic [DW-1:0]   DLY_LAST  = DW'(DELAY_CYCLES - 1);
    localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_ISSUE,
        S_WAIT_DONE, S_DELAY, S_DONE, S_ERROR
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_start_prev;
    logic [7:0]     r_rom_addr;
    logic [7:0]     r_reg_addr;
    logic [7:0]     r_data;
    logic           r_req;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic [RW-1:0]  r_retry;
    logic [DW-1:0]  r_dly_cnt;

    logic [7:0]     w_addr_nxt;
    logic [7:0]     w_reg_addr_nxt;
    logic [7:0]     w_data_nxt;
    logic [RW-1:0]  w_retry_nxt;
    logic [DW-1:0]  w_dly_nxt;
    logic           w_advance;
    logic           w_start;

    // Start is the high-to-low transition of the active-low request.
    assign w_start = r_start_prev & ~i_startConf;

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_rom_addr;
        w_reg_addr_nxt = r_reg_addr;
        w_data_nxt     = r_data;
        w_retry_nxt    = r_retry;
        w_dly_nxt      = r_dly_cnt;
        w_advance      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_start) begin
                    w_state_nxt = S_FETCH;
                    w_addr_nxt  = 8'd0;
                    w_retry_nxt = '0;
                end
            end
            S_FETCH: w_state_nxt = S_LATCH;
            S_LATCH: w_state_nxt = S_DECODE;
            S_DECODE: begin
                if (i_romData == 16'hFFFF) begin
                    w_state_nxt = S_DONE;
                end else if (i_romData == 16'hFFF0) begin
                    w_state_nxt = S_DELAY;
                    w_dly_nxt   = '0;
                end else begin
                    w_reg_addr_nxt = i_romData[15:8];
                    w_data_nxt     = i_romData[7:0];
                    w_state_nxt    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_sccbReady) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_sccbDone) begin
                    if (!i_sccbNack) begin
                        w_retry_nxt = '0;
                        w_advance   = 1'b1;
                    end else if (r_retry < RETRY_MAX) begin
                        w_retry_nxt = r_retry + RW'(1);
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_ERROR;
                    end
                end
            end
            S_DELAY: begin
                if (r_dly_cnt == DLY_LAST) w_advance = 1'b1;
                else                       w_dly_nxt = r_dly_cnt + DW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // The last ROM slot ends the sequence even without a terminator word.
        if (w_advance) begin
            if (r_rom_addr == LAST_ADDR) begin
                w_state_nxt = S_DONE;
            end else begin
                w_addr_nxt  = r_rom_addr + 8'd1;
                w_state_nxt = S_FETCH;
            end
        end
    end

    // Status outputs are registered copies of what the next state implies.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_start_prev <= 1'b1;
            r_rom_addr   <= 8'd0;
            r_reg_addr   <= 8'd0;
            r_data       <= 8'd0;
            r_req        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_retry      <= '0;
            r_dly_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_start_prev <= i_startConf;
            r_rom_addr   <= w_addr_nxt;
            r_reg_addr   <= w_reg_addr_nxt;
            r_data       <= w_data_nxt;
            r_req        <= (w_state_nxt == S_ISSUE);
            r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE) &&
                            (w_state_nxt != S_ERROR);
            r_done       <= (w_state_nxt == S_DONE);
            r_err        <= (w_state_nxt == S_ERROR);
            r_retry      <= w_retry_nxt;
            r_dly_cnt    <= w_dly_nxt;
        end
    end

    assign o_romAddr     = r_rom_addr;
    assign o_sccbReq     = r_req;
    assign o_sccbDevAddr = DEV_ADDR;
    assign o_sccbRegAddr = r_reg_addr;
    assign o_sccbData    = r_data;
    assign o_configBusy  = r_busy;
    assign o_configDone  = r_done;
    assign o_configErr   = r_err;

endmodule

// File: tb/tb_camera_config_seq.sv
// tb/tb_camera_config_seq.sv - self-checking bench for camera_config_seq
module tb_camera_config_seq;

    localparam int ROM_DEPTH    = 8;
    localparam int DELAY_CYCLES = 10;
    localparam int MAX_RETRY    = 3;

    localparam int P_IDLE = 0, P_REQ = 1, P_ACC = 2, P_WAIT = 3, P_PULSE = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_startConf;
    logic [7:0]  o_romAddr;
    logic [15:0] i_romData;
    logic        o_sccbReq;
    logic [7:0]  o_sccbDevAddr;
    logic [7:0]  o_sccbRegAddr;
    logic [7:0]  o_sccbData;
    logic        i_sccbReady;
    logic        i_sccbDone;
    logic        i_sccbNack;
    logic        o_configBusy;
    logic        o_configDone;
    logic        o_configErr;

    camera_config_seq #(
        .ROM_DEPTH(ROM_DEPTH), .DEV_ADDR(8'h42),
        .DELAY_CYCLES(DELAY_CYCLES), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_startConf(i_startConf),
        .o_romAddr(o_romAddr), .i_romData(i_romData),
        .o_sccbReq(o_sccbReq), .o_sccbDevAddr(o_sccbDevAddr),
        .o_sccbRegAddr(o_sccbRegAddr), .o_sccbData(o_sccbData),
        .i_sccbReady(i_sccbReady), .i_sccbDone(i_sccbDone), .i_sccbNack(i_sccbNack),
        .o_configBusy(o_configBusy), .o_configDone(o_configDone), .o_configErr(o_configErr)
    );

    always #5 i_clk = ~i_clk;

    logic [15:0] rom [0:255];
    int          nack_cnt [0:255];
    assign i_romData = rom[o_romAddr];

    int n_vec;
    int n_err;

    logic [7:0] e_ra[$];
    logic [7:0] e_rd[$];
    bit         e_nk[$];
    bit         e_done;
    bit         e_err;
    logic [7:0] e_addr;
    logic [7:0] act_ra[$];
    logic [7:0] act_rd[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected write list from the ROM contents and per-entry NACK counts.
    task automatic build_model();
        int a;
        bit fin;
        bit nk;
        e_ra.delete(); e_rd.delete(); e_nk.delete();
        e_done = 0; e_err = 0; a = 0; fin = 0;
        while (!fin) begin
            if (rom[a] == 16'hFFFF) begin
                e_done = 1; fin = 1;
            end else begin
                if (rom[a] != 16'hFFF0) begin
                    for (int t = 0; t <= MAX_RETRY; t++) begin
                        nk = (t < nack_cnt[a]);
                        e_ra.push_back(rom[a][15:8]);
                        e_rd.push_back(rom[a][7:0]);
                        e_nk.push_back(nk);
                        if (!nk) break;
                    end
                    if (nack_cnt[a] > MAX_RETRY) begin
                        e_err = 1; fin = 1;
                    end
                end
                if (!fin) begin
                    if (a == ROM_DEPTH - 1) begin
                        e_done = 1; fin = 1;
                    end else begin
                        a++;
                    end
                end
            end
        end
        e_addr = 8'(a);
    endtask

    task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'hFFFF;
            nack_cnt[i] = 0;
        end
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    endtask

    // Start pulse plus SCCB slave; NACKs follow the model's write order.
    task automatic run_seq(input int restart_at, input int rmin, input int rmax,
                           input bit abort, output int first_req);
        int k, phase, rwait, dwait, idx;
        logic [7:0] cra, crd;
        bit fin;
        act_ra.delete(); act_rd.delete();
        k = 0; phase = P_IDLE; idx = 0; fin = 0; first_req = -1;
        rwait = 0; dwait = 0; cra = 8'h0; crd = 8'h0;
        while (!fin) begin
            @(negedge i_clk);
            i_startConf = !((k < 5) || (k >= restart_at && k < restart_at + 3));
            if (phase == P_PULSE) begin
                i_sccbDone = 0; i_sccbNack = 0; phase = P_IDLE;
            end
            if (phase == P_ACC) begin
                i_sccbReady = 0;
                chk("req_drop", 32'(o_sccbReq), 32'd0);
                if (abort) begin
                    i_reset = 0;
                    #1;
                    return;
                end
                dwait = $urandom_range(0, 4);
                phase = P_WAIT;
            end
            if (phase == P_WAIT) begin
                if (dwait == 0) begin
                    i_sccbDone  = 1;
                    i_sccbNack  = (idx - 1 < int'(e_nk.size())) ? e_nk[idx-1] : 1'b0;
                    i_sccbReady = 0;
                    phase = P_PULSE;
                end else begin
                    dwait--;
                    i_sccbReady = 1'($urandom_range(0, 1));
                end
            end
            if (phase == P_IDLE) begin
                if (o_sccbReq) begin
                    cra = o_sccbRegAddr; crd = o_sccbData;
                    act_ra.push_back(cra); act_rd.push_back(crd);
                    idx++;
                    if (first_req < 0) first_req = k;
                    i_sccbDone = 0; i_sccbNack = 0;
                    rwait = $urandom_range(rmin, rmax);
                    phase = P_REQ;
                end else if (k >= 6 && (o_configDone || o_configErr)) begin
                    fin = 1;
                end else begin
                    i_sccbDone = ($urandom_range(0, 7) == 0);
                    i_sccbNack = 1'($urandom_range(0, 1));
                end
            end
            if (phase == P_REQ) begin
                chk("req_hold", 32'(o_sccbReq), 32'd1);
                chk("reg_stable", 32'(o_sccbRegAddr), 32'(cra));
                chk("dat_stable", 32'(o_sccbData), 32'(crd));
                chk("dev_addr", 32'(o_sccbDevAddr), 32'h42);
                if (rwait == 0) begin
                    i_sccbReady = 1; phase = P_ACC;
                end else begin
                    rwait--; i_sccbReady = 0;
                end
            end
            k++;
            if (!fin && k > 3000) begin
                chk("timeout", 32'(o_configDone | o_configErr), 32'd1);
                fin = 1;
            end
        end
        i_sccbDone = 0; i_sccbNack = 0; i_sccbReady = 0; i_startConf = 1;
    endtask

    task automatic check_result();
        chk("done", 32'(o_configDone), 32'(e_done));
        chk("err", 32'(o_configErr), 32'(e_err));
        chk("busy_end", 32'(o_configBusy), 32'd0);
        chk("rom_addr_end", 32'(o_romAddr), 32'(e_addr));
        chk("xfer_count", 32'(act_ra.size()), 32'(e_ra.size()));
        for (int i = 0; i < e_ra.size() && i < act_ra.size(); i++) begin
            chk("xfer_reg", 32'(act_ra[i]), 32'(e_ra[i]));
            chk("xfer_dat", 32'(act_rd[i]), 32'(e_rd[i]));
        end
        repeat (3) begin
            @(negedge i_clk);
            chk("hold_req", 32'(o_sccbReq), 32'd0);
            chk("hold_done", 32'(o_configDone), 32'(e_done));
            chk("hold_err", 32'(o_configErr), 32'(e_err));
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_rom_addr", 32'(o_romAddr), 32'd0);
        chk("rst_req", 32'(o_sccbReq), 32'd0);
        chk("rst_reg_addr", 32'(o_sccbRegAddr), 32'd0);
        chk("rst_data", 32'(o_sccbData), 32'd0);
        chk("rst_busy", 32'(o_configBusy), 32'd0);
        chk("rst_done", 32'(o_configDone), 32'd0);
        chk("rst_err", 32'(o_configErr), 32'd0);
        chk("rst_dev_addr", 32'(o_sccbDevAddr), 32'h42);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int r;
        n_vec = 0; n_err = 0;
        i_reset = 0; i_startConf = 1;
        i_sccbReady = 0; i_sccbDone = 0; i_sccbNack = 0;
        load_rom(16'h1280, 16'h0C04, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge i_clk);
        check_reset_outputs();
        i_reset = 1;
        repeat (3) @(negedge i_clk);
        chk("idle_busy", 32'(o_configBusy), 32'd0);
        chk("idle_req", 32'(o_sccbReq), 32'd0);

        // Two writes then terminator.
        build_model();
        run_seq(100000, 0, 3, 0, lat);
        check_result();

        // Slave holds off ready for 20 cycles per write.
        build_model();
        run_seq(100000, 20, 20, 0, lat);
        check_result();

        // Three NACKs then ACK on entry 0, then four NACKs to abort.
        load_rom(16'h1280, 16'h0C04, 16'hFFFF, 16'hFFFF);
        nack_cnt[0] = 3;
        build_model();
        run_seq(100000, 0, 2, 0, lat);
        check_result();
        nack_cnt[0] = 4;
        build_model();
        run_seq(100000, 0, 2, 0, lat);
        check_result();

        // Delay entry first; restart from ERROR.
        load_rom(16'hFFF0, 16'h1280, 16'hFFFF, 16'hFFFF);
        build_model();
        run_seq(100000, 0, 2, 0, lat);
        check_result();
        chk("delay_latency", 32'(lat >= DELAY_CYCLES + 3), 32'd1);

        // Second start while busy is ignored; start after DONE reruns.
        load_rom(16'h1280, 16'h0C04, 16'h1111, 16'hFFFF);
        build_model();
        run_seq(12, 2, 4, 0, lat);
        check_result();
        run_seq(100000, 0, 3, 0, lat);
        check_result();

        // No terminator: stops at the last ROM slot without wrapping.
        load_rom(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        for (int i = 4; i < ROM_DEPTH; i++) rom[i] = {8'(i), 8'(i * 3)};
        build_model();
        run_seq(100000, 0, 3, 0, lat);
        check_result();

        // Randomised ROM contents and NACK patterns.
        for (int it = 0; it < 8; it++) begin
            load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
            for (int i = 0; i < ROM_DEPTH; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)                rom[i] = 16'hFFF0;
                else if (r == 1 && i > 2)  rom[i] = 16'hFFFF;
                else                       rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
                n = $urandom_range(0, 15);
                nack_cnt[i] = (n < 9) ? 0 : (n - 9) % 5;
            end
            build_model();
            run_seq(100000, 0, 5, 0, lat);
            check_result();
        end

        // Reset while waiting for transfer completion.
        load_rom(16'h1280, 16'h0C04, 16'hFFFF, 16'hFFFF);
        build_model();
        run_seq(100000, 0, 2, 1, lat);
        check_reset_outputs();
        i_startConf = 1; i_sccbReady = 0; i_sccbDone = 0; i_sccbNack = 0;
        repeat (2) @(negedge i_clk);
        i_reset = 1;
        repeat (20) begin
            @(negedge i_clk);
            i_sccbDone = 1'($urandom_range(0, 1));
            i_sccbReady = 1'($urandom_range(0, 1));
            chk("post_rst_req", 32'(o_sccbReq), 32'd0);
            chk("post_rst_busy", 32'(o_configBusy), 32'd0);
        end
        i_sccbDone = 0; i_sccbReady = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
